// File: rtl/cubehash_msg_padder_pkg.sv
// Shared definitions for the CubeHash message padder: block geometry,
// one-hot FSM encoding and the padding constants.
package cubehash_msg_padder_pkg;

    localparam int          BLK_WORDS_DEF = 8;
    localparam logic [7:0]  PAD_BYTE      = 8'h80;
    localparam logic [31:0] PAD_WORD      = 32'h0000_0080;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_FILL = 4'b0010,
        ST_PAD  = 4'b0100,
        ST_OUT  = 4'b1000
    } state_t;

endpackage

// File: rtl/cubehash_msg_padder_pad_byte.sv
// Pads the final message word: keeps nbytes bytes, places 0x80 after them and
// zeroes the rest; flags a carry when the 0x80 must spill into the next slot.
module cubehash_pad_byte
    import cubehash_msg_padder_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [2:0]  nbytes_i,
    input  logic        last_i,
    output logic [31:0] word_o,
    output logic        carry_o
);

    // Byte-wise masking; out-of-range nbytes behaves as a full word
    always_comb begin
        word_o  = word_i;
        carry_o = 1'b0;
        if (last_i && (nbytes_i < 3'd4)) begin
            for (int b = 0; b < 4; b++) begin
                if (3'(b) < nbytes_i) begin
                    word_o[8*b +: 8] = word_i[8*b +: 8];
                end else if (3'(b) == nbytes_i) begin
                    word_o[8*b +: 8] = PAD_BYTE;
                end else begin
                    word_o[8*b +: 8] = 8'h00;
                end
            end
        end else if (last_i) begin
            carry_o = 1'b1;
        end else begin
            carry_o = 1'b0;
        end
    end

endmodule

// File: rtl/cubehash_msg_padder.sv
// Assembles 32-bit message words into CubeHash blocks, appending the 0x80
// padding byte and zero fill, and presents blocks with a valid/ready handshake.
module cubehash_msg_padder
    import cubehash_msg_padder_pkg::*;
#(
    parameter int BLK_WORDS = BLK_WORDS_DEF
) (
    input  logic                   clk,
    input  logic                   rst_p,
    input  logic [31:0]            s_data,
    input  logic                   s_valid,
    input  logic                   s_last,
    input  logic [2:0]             s_nbytes,
    output logic                   s_ready,
    output logic [32*BLK_WORDS-1:0] blk_data,
    output logic                   blk_valid,
    input  logic                   blk_ready,
    output logic                   blk_last,
    output logic                   start,
    output logic                   in_en,
    output logic                   err
);

    localparam int            CW        = $clog2(BLK_WORDS);
    localparam logic [CW-1:0] LAST_SLOT = CW'(BLK_WORDS - 1);

    state_t                  state_q, state_d;
    logic [CW-1:0]           wcnt_q, wcnt_d;
    logic [32*BLK_WORDS-1:0] blk_q, blk_d;
    logic                    pad80_q, pad80_d;
    logic                    pend_q, pend_d;
    logic                    has80_q, has80_d;
    logic                    first_q, first_d;
    logic                    s_ready_q, s_ready_d;
    logic                    blk_valid_q, blk_valid_d;
    logic                    blk_last_q, blk_last_d;
    logic                    start_q, start_d;
    logic                    in_en_q, in_en_d;
    logic                    err_q, err_d;

    logic [31:0] pad_word_s;
    logic        carry_s;
    logic        accept_s;
    logic        wrap_s;
    logic [31:0] slot_val_s;

    cubehash_pad_byte u_pad_byte (
        .word_i   (s_data),
        .nbytes_i (s_nbytes),
        .last_i   (s_last),
        .word_o   (pad_word_s),
        .carry_o  (carry_s)
    );

    assign accept_s = s_valid && s_ready_q;
    assign wrap_s   = (wcnt_q == LAST_SLOT);

    // Next-state, slot writes and registered-output decode
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        blk_d       = blk_q;
        pad80_d     = pad80_q;
        pend_d      = pend_q;
        has80_d     = has80_q;
        first_d     = first_q;
        in_en_d     = in_en_q;
        err_d       = err_q;
        blk_last_d  = blk_last_q;
        start_d     = start_q;
        slot_val_s  = 32'h0000_0000;

        case (state_q)
            ST_IDLE, ST_FILL: begin
                if (accept_s) begin
                    if (state_q == ST_IDLE) begin
                        blk_d   = '0;
                        first_d = 1'b1;
                        in_en_d = 1'b1;
                    end else begin
                        first_d = first_q;
                    end
                    slot_val_s = pad_word_s;
                    for (int i = 0; i < BLK_WORDS; i++) begin
                        if (wcnt_q == CW'(i)) begin
                            blk_d[32*i +: 32] = slot_val_s;
                        end else begin
                            blk_d[32*i +: 32] = blk_d[32*i +: 32];
                        end
                    end
                    wcnt_d = wcnt_q + CW'(1);
                    if ((s_nbytes > 3'd4) || ((s_nbytes != 3'd4) && !s_last)) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    // A full last word pushes the 0x80 into the next slot,
                    // or into a fresh block when this one is already full
                    if (s_last && !carry_s) begin
                        has80_d = 1'b1;
                    end else if (s_last && !wrap_s) begin
                        has80_d = 1'b1;
                        pad80_d = 1'b1;
                    end else if (s_last) begin
                        pend_d = 1'b1;
                    end else begin
                        has80_d = has80_q;
                    end
                    if (wrap_s) begin
                        state_d = ST_OUT;
                    end else if (s_last) begin
                        state_d = ST_PAD;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_PAD: begin
                slot_val_s = pad80_q ? PAD_WORD : 32'h0000_0000;
                for (int i = 0; i < BLK_WORDS; i++) begin
                    if (wcnt_q == CW'(i)) begin
                        blk_d[32*i +: 32] = slot_val_s;
                    end else begin
                        blk_d[32*i +: 32] = blk_q[32*i +: 32];
                    end
                end
                pad80_d = 1'b0;
                wcnt_d  = wcnt_q + CW'(1);
                if (wrap_s) begin
                    state_d = ST_OUT;
                end else begin
                    state_d = ST_PAD;
                end
            end
            ST_OUT: begin
                if (blk_ready) begin
                    blk_d   = '0;
                    wcnt_d  = '0;
                    first_d = 1'b0;
                    has80_d = 1'b0;
                    if (blk_last_q) begin
                        state_d = ST_IDLE;
                    end else if (pend_q) begin
                        state_d = ST_PAD;
                        pad80_d = 1'b1;
                        pend_d  = 1'b0;
                        has80_d = 1'b1;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                wcnt_d  = '0;
                blk_d   = '0;
            end
        endcase

        s_ready_d   = (state_d == ST_IDLE) || (state_d == ST_FILL);
        blk_valid_d = (state_d == ST_OUT);
        // Block attributes are latched on entry to OUT and held until handshake
        if ((state_d == ST_OUT) && (state_q != ST_OUT)) begin
            blk_last_d = has80_d;
            start_d    = first_d;
            in_en_d    = in_en_d & ~has80_d;
        end else if (state_d != ST_OUT) begin
            blk_last_d = 1'b0;
            start_d    = 1'b0;
        end else begin
            blk_last_d = blk_last_q;
            start_d    = start_q;
        end
        if (state_d == ST_IDLE) begin
            in_en_d = 1'b0;
        end else begin
            in_en_d = in_en_d;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst_p) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            blk_q       <= '0;
            pad80_q     <= 1'b0;
            pend_q      <= 1'b0;
            has80_q     <= 1'b0;
            first_q     <= 1'b0;
            s_ready_q   <= 1'b1;
            blk_valid_q <= 1'b0;
            blk_last_q  <= 1'b0;
            start_q     <= 1'b0;
            in_en_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            blk_q       <= blk_d;
            pad80_q     <= pad80_d;
            pend_q      <= pend_d;
            has80_q     <= has80_d;
            first_q     <= first_d;
            s_ready_q   <= s_ready_d;
            blk_valid_q <= blk_valid_d;
            blk_last_q  <= blk_last_d;
            start_q     <= start_d;
            in_en_q     <= in_en_d;
            err_q       <= err_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign blk_data  = blk_q;
    assign blk_valid = blk_valid_q;
    assign blk_last  = blk_last_q;
    assign start     = start_q;
    assign in_en     = in_en_q;
    assign err       = err_q;

endmodule

// File: tb/tb_cubehash_msg_padder.sv
// Directed bench for cubehash_msg_padder: each scenario task drives words,
// collects blocks and compares against hand-computed blocks.
module tb_cubehash_msg_padder;

    logic         clk = 1'b0;
    logic         rst_p;
    logic [31:0]  s_data;
    logic         s_valid;
    logic         s_last;
    logic [2:0]   s_nbytes;
    logic         s_ready;
    logic [255:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic         blk_last;
    logic         start;
    logic         in_en;
    logic         err;

    int checks   = 0;
    int failures = 0;

    cubehash_msg_padder #(.BLK_WORDS(8)) dut (
        .clk       (clk),
        .rst_p     (rst_p),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_nbytes  (s_nbytes),
        .s_ready   (s_ready),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_last  (blk_last),
        .start     (start),
        .in_en     (in_en),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] mk_blk(input logic [31:0] w0, w1, w2, w3,
                                            w4, w5, w6, w7);
        return {w7, w6, w5, w4, w3, w2, w1, w0};
    endfunction

    // Present one word and hold it until accepted; ok=0 if it never is
    task automatic send(input logic [31:0] d, input logic [2:0] nb,
                        input logic last, output bit ok);
        int n = 0;
        s_data = d; s_nbytes = nb; s_last = last; s_valid = 1'b1;
        while (!s_ready && n < 60) begin
            @(posedge clk); #1; n++;
        end
        ok = s_ready;
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0; s_nbytes = 3'd4;
    endtask

    // Wait for a block, capture it, then complete the handshake
    task automatic get_blk(output bit got, output logic [255:0] d,
                           output logic l, output logic st, output logic ie);
        int n = 0;
        while (!blk_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        got = blk_valid; d = blk_data; l = blk_last; st = start; ie = in_en;
        blk_ready = 1'b1;
        @(posedge clk); #1;
        blk_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_p = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst_p = 1'b0;
        checks++;
        if ({s_ready, blk_valid, blk_last, start, in_en, err} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=100000",
                     {s_ready, blk_valid, blk_last, start, in_en, err});
        end
        checks++;
        if (blk_data !== 256'd0) begin
            failures++; $display("FAIL reset_data got=%h exp=0", blk_data);
        end
    endtask

    task automatic test_two_blocks_plus_pad();
        logic [255:0] d[3]; logic l[3], st[3], ie[3]; bit got[3]; bit ok;
        logic [255:0] e1, e2;
        for (int k = 0; k < 8; k++) begin
            e1[32*k +: 32] = 32'h0302_0100 + 32'(k) * 32'h0404_0404;
            e2[32*k +: 32] = 32'h0302_0100 + 32'(k + 8) * 32'h0404_0404;
        end
        fork
            begin
                for (int k = 0; k < 16; k++) begin
                    send(32'h0302_0100 + 32'(k) * 32'h0404_0404, 3'd4, k == 15, ok);
                    checks++;
                    if (ok !== 1'b1) begin
                        failures++; $display("FAIL b3_accept_%0d got=%b exp=1", k, ok);
                    end
                end
            end
            begin
                for (int b = 0; b < 3; b++) get_blk(got[b], d[b], l[b], st[b], ie[b]);
            end
        join
        checks++;
        if ({got[0], got[1], got[2]} !== 3'b111) begin
            failures++; $display("FAIL b3_got got=%b exp=111", {got[0], got[1], got[2]});
        end
        checks++;
        if (d[0] !== e1) begin failures++; $display("FAIL b3_blk1 got=%h exp=%h", d[0], e1); end
        checks++;
        if (d[1] !== e2) begin failures++; $display("FAIL b3_blk2 got=%h exp=%h", d[1], e2); end
        checks++;
        if (d[2] !== mk_blk(32'h80, 0, 0, 0, 0, 0, 0, 0)) begin
            failures++; $display("FAIL b3_blk3 got=%h exp=80", d[2]);
        end
        checks++;
        if ({l[0], l[1], l[2], st[0], st[1], st[2], ie[0], ie[1], ie[2]} !== 9'b001_100_110) begin
            failures++;
            $display("FAIL b3_flags got=%b exp=001100110",
                     {l[0], l[1], l[2], st[0], st[1], st[2], ie[0], ie[1], ie[2]});
        end
    endtask

    task automatic test_short_last();
        logic [255:0] d; logic l, st, ie; bit got, ok;
        send(32'h0302_0100, 3'd4, 1'b0, ok);
        checks++;
        if (in_en !== 1'b1) begin failures++; $display("FAIL short_in_en_fill got=%b exp=1", in_en); end
        send(32'h0706_0504, 3'd4, 1'b0, ok);
        send(32'h0000_00AA, 3'd1, 1'b1, ok);
        get_blk(got, d, l, st, ie);
        checks++;
        if (d !== mk_blk(32'h0302_0100, 32'h0706_0504, 32'h0000_80AA, 0, 0, 0, 0, 0)) begin
            failures++; $display("FAIL short_data got=%h", d);
        end
        checks++;
        if ({got, l, st, ie} !== 4'b1110) begin
            failures++; $display("FAIL short_flags got=%b exp=1110", {got, l, st, ie});
        end
    endtask

    task automatic test_empty();
        logic [255:0] d; logic l, st, ie; bit got, ok;
        send(32'hDEAD_BEEF, 3'd0, 1'b1, ok);
        get_blk(got, d, l, st, ie);
        checks++;
        if (d !== mk_blk(32'h0000_0080, 0, 0, 0, 0, 0, 0, 0)) begin
            failures++; $display("FAIL empty_data got=%h exp=80", d);
        end
        checks++;
        if ({got, l, st, ie} !== 4'b1110) begin
            failures++; $display("FAIL empty_flags got=%b exp=1110", {got, l, st, ie});
        end
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if ({blk_valid, s_ready} !== 2'b01) begin
            failures++; $display("FAIL empty_single got=%b exp=01", {blk_valid, s_ready});
        end
    endtask

    task automatic test_backpressure();
        logic [255:0] exp_d; bit ok; int n;
        for (int k = 0; k < 7; k++) begin
            send(32'h5000_0000 + 32'(k), 3'd4, 1'b0, ok);
            exp_d[32*k +: 32] = 32'h5000_0000 + 32'(k);
        end
        send(32'hAABB_CCDD, 3'd3, 1'b1, ok);
        exp_d[255:224] = 32'h80BB_CCDD;
        n = 0;
        while (!blk_valid && n < 20) begin @(posedge clk); #1; n++; end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({blk_valid, s_ready, blk_last} !== 3'b101 || blk_data !== exp_d) begin
                failures++;
                $display("FAIL stall_cyc%0d got=%b/%h exp=101/%h",
                         c, {blk_valid, s_ready, blk_last}, blk_data, exp_d);
            end
            @(posedge clk); #1;
        end
        blk_ready = 1'b1;
        @(posedge clk); #1;
        blk_ready = 1'b0;
        checks++;
        if ({blk_valid, s_ready} !== 2'b01) begin
            failures++; $display("FAIL stall_release got=%b exp=01", {blk_valid, s_ready});
        end
    endtask

    task automatic test_err_and_midreset();
        logic [255:0] d[2], e1; logic l[2], st[2], ie[2]; bit got[2], ok; bit seen;
        send(32'h1111_1111, 3'd2, 1'b0, ok);
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", err); end
        for (int k = 0; k < 4; k++) send(32'h2222_2222, 3'd4, 1'b0, ok);
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", err); end
        rst_p = 1'b1;
        @(posedge clk); #1;
        rst_p = 1'b0;
        checks++;
        if ({err, in_en, s_ready} !== 3'b001) begin
            failures++; $display("FAIL midrst_flags got=%b exp=001", {err, in_en, s_ready});
        end
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (blk_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL midrst_noblk got=%b exp=0", seen); end
        for (int k = 0; k < 8; k++) e1[32*k +: 32] = 32'h1000_0000 + 32'(k);
        fork
            begin
                for (int k = 0; k < 8; k++) send(32'h1000_0000 + 32'(k), 3'd4, k == 7, ok);
            end
            begin
                get_blk(got[0], d[0], l[0], st[0], ie[0]);
                get_blk(got[1], d[1], l[1], st[1], ie[1]);
            end
        join
        checks++;
        if (d[0] !== e1 || got[0] !== 1'b1) begin
            failures++; $display("FAIL midrst_blk1 got=%h exp=%h", d[0], e1);
        end
        checks++;
        if ({l[0], st[0], ie[0], got[1], l[1], st[1], ie[1]} !== 7'b011_1100) begin
            failures++;
            $display("FAIL midrst_flags2 got=%b exp=0111100",
                     {l[0], st[0], ie[0], got[1], l[1], st[1], ie[1]});
        end
        checks++;
        if (d[1] !== mk_blk(32'h80, 0, 0, 0, 0, 0, 0, 0)) begin
            failures++; $display("FAIL midrst_blk2 got=%h exp=80", d[1]);
        end
    endtask

    initial begin
        rst_p = 1'b1; s_data = 32'd0; s_valid = 1'b0; s_last = 1'b0;
        s_nbytes = 3'd4; blk_ready = 1'b0;
        #1;
        test_reset();
        test_two_blocks_plus_pad();
        test_short_last();
        test_empty();
        test_backpressure();
        test_err_and_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
